// File: rtl/seven_seg_bank.sv
// Multi-digit seven-segment driver: hex or decimal (double-dabble) rendering, leading-zero blanking, overflow dashes.
// Load is registered one cycle before the FSM acts on it; hex/done land 2 edges (hex) or VAL_W+2 edges (decimal) after load.
module seven_seg_bank #(
    parameter int N_DIGITS = 4,
    parameter int VAL_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  mode_dec,
    input  logic                  lz_blank,
    input  logic [VAL_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [7*N_DIGITS-1:0] hex
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int EXT_W = (BCD_W > VAL_W) ? BCD_W : VAL_W;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [VAL_W-1:0]     val_q, val_d;
    logic                 dec_q, dec_d;
    logic                 lz_q, lz_d;
    logic [VAL_W-1:0]     sr_q, sr_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [7*N_DIGITS-1:0] hex_q, hex_d;

    logic [BCD_W-1:0]     adj;
    logic [BCD_W-1:0]     step_bcd;
    logic [VAL_W-1:0]     step_sr;
    logic                 step_ovf;
    logic [EXT_W-1:0]     val_ext;
    logic                 hex_ovf;
    logic                 frame_ovf;
    logic                 seen;
    logic [3:0]           nib;
    logic [7*N_DIGITS-1:0] frame;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        glyph = BLANK;
        case (d)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  4'hF: glyph = 7'h0E;
            default: glyph = BLANK;
        endcase
    endfunction

    // One double-dabble step; a 1 leaving the top BCD digit means the value needs more digits.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        step_ovf = ovf_q | adj[BCD_W-1];
        step_bcd = {adj[BCD_W-2:0], sr_q[VAL_W-1]};
        step_sr  = sr_q << 1;
    end

    assign val_ext = EXT_W'(val_q);
    assign hex_ovf = |(val_ext >> BCD_W);

    always_comb begin
        frame     = '1;
        seen      = 1'b0;
        nib       = 4'd0;
        frame_ovf = dec_q ? ovf_q : hex_ovf;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            nib = dec_q ? bcd_q[4*i +: 4] : val_ext[4*i +: 4];
            if (nib != 4'd0) seen = 1'b1;
            if (frame_ovf)                       frame[7*i +: 7] = DASH;
            else if (lz_q && !seen && (i != 0))  frame[7*i +: 7] = BLANK;
            else                                 frame[7*i +: 7] = glyph(nib);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        val_d   = val_q;
        dec_d   = dec_q;
        lz_d    = lz_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (dec_q) begin
                        state_d = CONV;
                        sr_d    = val_q;
                        bcd_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = UPDATE;
                    end
                end else if (load) begin
                    pend_d = 1'b1;
                    val_d  = value;
                    dec_d  = mode_dec;
                    lz_d   = lz_blank;
                end
            end
            CONV: begin
                sr_d  = step_sr;
                bcd_d = step_bcd;
                ovf_d = step_ovf;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VAL_W - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                hex_d   = frame;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CONV) || ((state_d == UPDATE) && dec_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            val_q   <= '0;
            dec_q   <= 1'b0;
            lz_q    <= 1'b0;
            sr_q    <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            val_q   <= val_d;
            dec_q   <= dec_d;
            lz_q    <= lz_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hex  = hex_q;

endmodule
